// File: rtl/mastermind_row_scorer.sv
`default_nettype none
// ==========================================================================
// Module : mastermind_row_scorer
// Scores one MasterMind guess row and streams pins and hints into board RAM.
// Optional macro SCORER_RANGE_CHECK_EN enables the colour range check.
// Rev    : 1.0
// ==========================================================================
module mastermind_row_scorer #(
  parameter int MAX_PINS     = 16,
  parameter int COLOR_W      = 5,
  parameter int ADDR_W       = 12,
  parameter int HINTS_OFFSET = 2048
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  input  logic                        abort,
  input  logic [7:0]                  pins_count,
  input  logic [7:0]                  pin_colors,
  input  logic [7:0]                  row,
  input  logic [MAX_PINS*COLOR_W-1:0] guess,
  input  logic [MAX_PINS*COLOR_W-1:0] secret,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  green,
  output logic [7:0]                  yellow,
  output logic                        win,
  output logic                        err,
  output logic                        ram_wen,
  output logic [ADDR_W-1:0]           ram_waddr,
  output logic [7:0]                  ram_wdata
);
  localparam int IDX_W = $clog2(MAX_PINS + 1);
  localparam int AW    = ADDR_W + 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_HINT_Y = 3'd3,
    S_HINT_G = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                      state_q, state_d;
  logic [MAX_PINS*COLOR_W-1:0] guess_q, guess_d, secret_q, secret_d;
  logic [IDX_W-1:0]            pcnt_q, pcnt_d, idx_q, idx_d;
  logic [7:0]                  row_q, row_d, green_q, green_d, yellow_q, yellow_d;
  logic [MAX_PINS-1:0]         gmask_q, gmask_d, smask_q, smask_d;
  logic                        win_q, win_d;
  logic                        err_w;

  logic [IDX_W-1:0]   p_eff, last_idx, found_idx;
  logic [COLOR_W-1:0] cur_guess, cur_secret;
  logic               cur_gmask, found;

  assign p_eff    = (int'(pins_count) > MAX_PINS) ? IDX_W'(MAX_PINS) : IDX_W'(pins_count);
  assign last_idx = pcnt_q - IDX_W'(1);

  always_comb begin
    cur_guess  = '0;
    cur_secret = '0;
    cur_gmask  = 1'b0;
    for (int k = 0; k < MAX_PINS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_guess  = guess_q[k*COLOR_W +: COLOR_W];
        cur_secret = secret_q[k*COLOR_W +: COLOR_W];
        cur_gmask  = gmask_q[k];
      end
    end
  end

  // Scanning downward lets the lowest matching secret slot win.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int s = MAX_PINS - 1; s >= 0; s--) begin
      if ((IDX_W'(s) < pcnt_q) && !smask_q[s] &&
          (secret_q[s*COLOR_W +: COLOR_W] == cur_guess)) begin
        found     = 1'b1;
        found_idx = IDX_W'(s);
      end
    end
  end

`ifdef SCORER_RANGE_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start && !abort) begin
      err_d = 1'b0;
    end else if (state_q == S_GREEN && !abort && (8'(cur_guess) >= pin_colors)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_w = err_q;
`else
  logic unused_pin_colors;
  assign unused_pin_colors = ^pin_colors;
  assign err_w             = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    secret_d = secret_q;
    pcnt_d   = pcnt_q;
    row_d    = row_q;
    idx_d    = idx_q;
    green_d  = green_q;
    yellow_d = yellow_q;
    gmask_d  = gmask_q;
    smask_d  = smask_q;
    win_d    = win_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            guess_d  = guess;
            secret_d = secret;
            pcnt_d   = p_eff;
            row_d    = row;
            idx_d    = '0;
            green_d  = '0;
            yellow_d = '0;
            gmask_d  = '0;
            smask_d  = '0;
            win_d    = 1'b0;
            state_d  = (p_eff == '0) ? S_HINT_Y : S_GREEN;
          end
        end
        S_GREEN: begin
          if (cur_guess == cur_secret) begin
            green_d = green_q + 8'd1;
            for (int k = 0; k < MAX_PINS; k++) begin
              if (idx_q == IDX_W'(k)) begin
                gmask_d[k] = 1'b1;
                smask_d[k] = 1'b1;
              end
            end
          end
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = S_YELLOW;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_YELLOW: begin
          if (!cur_gmask && found) begin
            yellow_d = yellow_q + 8'd1;
            for (int k = 0; k < MAX_PINS; k++) begin
              if (found_idx == IDX_W'(k)) smask_d[k] = 1'b1;
              if (idx_q == IDX_W'(k))     gmask_d[k] = 1'b1;
            end
          end
          if (idx_q == last_idx) state_d = S_HINT_Y;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
        S_HINT_Y: state_d = S_HINT_G;
        S_HINT_G: begin
          state_d = S_DONE;
          win_d   = (green_q == 8'(pcnt_q)) && (pcnt_q != '0) && !err_w;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_wen   = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (!abort) begin
      case (state_q)
        S_GREEN: begin
          ram_wen   = 1'b1;
          ram_waddr = ADDR_W'(AW'(row_q) * AW'(MAX_PINS) + AW'(idx_q));
          ram_wdata = 8'(cur_guess);
        end
        S_HINT_Y: begin
          ram_wen   = 1'b1;
          ram_waddr = ADDR_W'(AW'(HINTS_OFFSET) + (AW'(row_q) << 1));
          ram_wdata = err_w ? 8'hFF : yellow_q;
        end
        S_HINT_G: begin
          ram_wen   = 1'b1;
          ram_waddr = ADDR_W'(AW'(HINTS_OFFSET) + (AW'(row_q) << 1) + AW'(1));
          ram_wdata = err_w ? 8'hFF : green_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      secret_q <= '0;
      pcnt_q   <= '0;
      row_q    <= '0;
      idx_q    <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      gmask_q  <= '0;
      smask_q  <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      secret_q <= secret_d;
      pcnt_q   <= pcnt_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      gmask_q  <= gmask_d;
      smask_q  <= smask_d;
      win_q    <= win_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign green  = green_q;
  assign yellow = yellow_q;
  assign win    = win_q;
  assign err    = err_w;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_row_scorer.sv
`default_nettype none
// Testbench for mastermind_row_scorer: directed and random rows against a
// colour-counting reference model, plus start/abort/reset control scenarios.
module tb_mastermind_row_scorer;
  localparam int MAX_PINS     = 16;
  localparam int COLOR_W      = 5;
  localparam int ADDR_W       = 12;
  localparam int HINTS_OFFSET = 2048;
  localparam int PW           = MAX_PINS * COLOR_W;
  localparam int NC           = 1 << COLOR_W;

  logic              CLK = 1'b0;
  logic              RST_N, start, abort;
  logic [7:0]        pins_count, pin_colors, row;
  logic [PW-1:0]     guess, secret;
  logic              busy, done, win, err, ram_wen;
  logic [7:0]        green, yellow, ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [7:0]        wd_q[$];
  int                done_cyc;
  logic [7:0]        got_green, got_yellow;
  logic              got_win, got_err;

  always #5 CLK = ~CLK;

  mastermind_row_scorer #(
    .MAX_PINS(MAX_PINS), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .HINTS_OFFSET(HINTS_OFFSET)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
    .pins_count(pins_count), .pin_colors(pin_colors), .row(row),
    .guess(guess), .secret(secret), .busy(busy), .done(done),
    .green(green), .yellow(yellow), .win(win), .err(err),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
  );

  function automatic logic [PW-1:0] pack5(input int a, input int b, input int c,
                                          input int d, input int e);
    logic [PW-1:0] r;
    r = '0;
    r[0*COLOR_W +: COLOR_W] = COLOR_W'(a);
    r[1*COLOR_W +: COLOR_W] = COLOR_W'(b);
    r[2*COLOR_W +: COLOR_W] = COLOR_W'(c);
    r[3*COLOR_W +: COLOR_W] = COLOR_W'(d);
    r[4*COLOR_W +: COLOR_W] = COLOR_W'(e);
    return r;
  endfunction

  function automatic logic [PW-1:0] rand_pins(input int max_col);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_PINS; i++) r[i*COLOR_W +: COLOR_W] = COLOR_W'($urandom_range(0, max_col));
    return r;
  endfunction

  function automatic int pin(input logic [PW-1:0] v, input int i);
    return int'(v[i*COLOR_W +: COLOR_W]);
  endfunction

  // Classic scoring: yellow = sum over colours of min(count) minus exact hits.
  task automatic model(input logic [PW-1:0] g, input logic [PW-1:0] s, input logic [7:0] pc,
                       input logic [7:0] pcol, output int p, output int gr, output int ye,
                       output logic er);
    int cg[NC];
    int cs[NC];
    int tot;
    p  = (int'(pc) > MAX_PINS) ? MAX_PINS : int'(pc);
    gr = 0;
    tot = 0;
    er = 1'b0;
    for (int c = 0; c < NC; c++) begin cg[c] = 0; cs[c] = 0; end
    for (int i = 0; i < p; i++) begin
      if (pin(g, i) == pin(s, i)) gr++;
      cg[pin(g, i)]++;
      cs[pin(s, i)]++;
      if (pin(g, i) >= int'(pcol)) er = 1'b1;
    end
    for (int c = 0; c < NC; c++) tot += (cg[c] < cs[c]) ? cg[c] : cs[c];
    ye = tot - gr;
`ifndef SCORER_RANGE_CHECK_EN
    er = 1'b0;
`endif
  endtask

  task automatic issue(input logic [7:0] pc, input logic [7:0] rw, input logic [7:0] pcol,
                       input logic [PW-1:0] g, input logic [PW-1:0] s);
    @(posedge CLK);
    @(negedge CLK);
    pins_count = pc;
    row        = rw;
    pin_colors = pcol;
    guess      = g;
    secret     = s;
    start      = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  // Records RAM writes from cycle 1 until done (or the cycle limit); not a checker.
  task automatic collect(input int limit);
    wa_q.delete();
    wd_q.delete();
    done_cyc = -1;
    for (int c = 1; c <= limit && done_cyc < 0; c++) begin
      if (ram_wen) begin
        wa_q.push_back(ram_waddr);
        wd_q.push_back(ram_wdata);
      end
      if (done) begin
        done_cyc   = c;
        got_green  = green;
        got_yellow = yellow;
        got_win    = win;
        got_err    = err;
      end else begin
        @(posedge CLK);
        #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, win, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy/done/win/err=%b expected 0000", {busy, done, win, err});
    end
    checks++;
    if ({green, yellow} !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts got green=%0d yellow=%0d expected 0/0", green, yellow);
    end
    checks++;
    if ({ram_wen, ram_waddr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_ram got wen=%b addr=%0h data=%0h expected zeros", ram_wen, ram_waddr, ram_wdata);
    end
  endtask

  task automatic test_scoring;
    logic [PW-1:0] tg[5], ts[5];
    logic [7:0]    tpc[5], trw[5];
    logic [PW-1:0] g, s;
    logic [7:0]    pc, rw, pcol;
    logic [ADDR_W-1:0] exp_a[$];
    logic [7:0]        exp_d[$];
    int p, gr, ye, hb, bad;
    logic er, ew;
    tg[0] = pack5(1, 2, 1, 3, 0); ts[0] = pack5(1, 1, 2, 3, 0); tpc[0] = 8'd4;   trw[0] = 8'd3;
    tg[1] = pack5(1, 1, 1, 1, 0); ts[1] = pack5(0, 0, 0, 1, 0); tpc[1] = 8'd4;   trw[1] = 8'd10;
    tg[2] = pack5(4, 4, 4, 4, 4); ts[2] = pack5(4, 4, 4, 4, 4); tpc[2] = 8'd5;   trw[2] = 8'd0;
    tg[3] = rand_pins(7);         ts[3] = rand_pins(7);         tpc[3] = 8'd0;   trw[3] = 8'd7;
    tg[4] = rand_pins(3);         ts[4] = rand_pins(3);         tpc[4] = 8'd200; trw[4] = 8'd255;
    for (int n = 0; n < 35; n++) begin
      if (n < 5) begin
        g = tg[n]; s = ts[n]; pc = tpc[n]; rw = trw[n]; pcol = 8'hFF;
      end else begin
        g    = rand_pins(5);
        s    = rand_pins(5);
        pc   = 8'($urandom_range(0, 20));
        rw   = 8'($urandom_range(0, 255));
        pcol = 8'($urandom_range(4, 8));
      end
      model(g, s, pc, pcol, p, gr, ye, er);
      ew = (gr == p) && (p != 0) && !er;
      exp_a.delete();
      exp_d.delete();
      for (int i = 0; i < p; i++) begin
        exp_a.push_back(ADDR_W'(int'(rw) * MAX_PINS + i));
        exp_d.push_back(8'(pin(g, i)));
      end
      hb = HINTS_OFFSET + 2 * int'(rw);
      exp_a.push_back(ADDR_W'(hb));
      exp_d.push_back(er ? 8'hFF : 8'(ye));
      exp_a.push_back(ADDR_W'(hb + 1));
      exp_d.push_back(er ? 8'hFF : 8'(gr));

      issue(pc, rw, pcol, g, s);
      collect(60);

      checks++;
      if (done_cyc != 2 * p + 3) begin
        errors++;
        $display("FAIL row%0d done_cycle got %0d expected %0d", n, done_cyc, 2 * p + 3);
      end
      checks++;
      if (got_green !== 8'(gr)) begin
        errors++;
        $display("FAIL row%0d green got %0d expected %0d", n, got_green, gr);
      end
      checks++;
      if (got_yellow !== 8'(ye)) begin
        errors++;
        $display("FAIL row%0d yellow got %0d expected %0d", n, got_yellow, ye);
      end
      checks++;
      if (got_win !== ew) begin
        errors++;
        $display("FAIL row%0d win got %b expected %b", n, got_win, ew);
      end
      checks++;
      if (got_err !== er) begin
        errors++;
        $display("FAIL row%0d err got %b expected %b", n, got_err, er);
      end
      bad = -1;
      if (wa_q.size() == exp_a.size()) begin
        for (int i = exp_a.size() - 1; i >= 0; i--)
          if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) bad = i;
      end
      checks++;
      if (wa_q.size() != exp_a.size() || bad >= 0) begin
        errors++;
        $display("FAIL row%0d ram_writes got %0d writes expected %0d, first bad index %0d",
                 n, wa_q.size(), exp_a.size(), bad);
        if (bad >= 0)
          $display("  index %0d got addr=%0h data=%0h expected addr=%0h data=%0h",
                   bad, wa_q[bad], wd_q[bad], exp_a[bad], exp_d[bad]);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || green !== 8'(gr) || yellow !== 8'(ye)) begin
        errors++;
        $display("FAIL row%0d after_done got busy=%b done=%b green=%0d yellow=%0d expected 0/0/%0d/%0d",
                 n, busy, done, green, yellow, gr, ye);
      end
    end
  endtask

  task automatic test_busy_start;
    logic [PW-1:0] g, s;
    int p, gr, ye;
    logic er;
    g = rand_pins(3);
    s = rand_pins(3);
    model(g, s, 8'd4, 8'hFF, p, gr, ye, er);
    issue(8'd4, 8'd9, 8'hFF, g, s);
    start      = 1'b1;
    pins_count = 8'd16;
    row        = 8'd0;
    guess      = rand_pins(7);
    secret     = rand_pins(7);
    collect(60);
    checks++;
    if (done_cyc != 11 || got_green !== 8'(gr) || got_yellow !== 8'(ye)) begin
      errors++;
      $display("FAIL busy_start got done_cyc=%0d green=%0d yellow=%0d expected 11/%0d/%0d",
               done_cyc, got_green, got_yellow, gr, ye);
    end
    checks++;
    if (wa_q.size() != 6 || wa_q[0] !== ADDR_W'(9 * MAX_PINS)) begin
      errors++;
      $display("FAIL busy_start_writes got %0d writes expected 6 starting at %0h", wa_q.size(), 9 * MAX_PINS);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_restart got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort;
    logic [PW-1:0] g, s;
    int wens, dones;
    g = rand_pins(7);
    s = rand_pins(7);
    for (int i = 0; i < 4; i++) s[i*COLOR_W +: COLOR_W] = g[i*COLOR_W +: COLOR_W];
    s[4*COLOR_W +: COLOR_W] = g[4*COLOR_W +: COLOR_W] ^ COLOR_W'(1);
    issue(8'd16, 8'd2, 8'hFF, g, s);
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    abort = 1'b1;
    @(posedge CLK);
    #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b expected 0", busy);
    end
    checks++;
    if (green !== 8'd4 || yellow !== 8'd0) begin
      errors++;
      $display("FAIL abort_partial got green=%0d yellow=%0d expected 4/0", green, yellow);
    end
    wens  = 0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (ram_wen) wens++;
      if (done) dones++;
      @(posedge CLK);
      #1;
    end
    checks++;
    if (wens != 0 || dones != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d ram_wen and %0d done cycles expected 0/0", wens, dones);
    end
    @(negedge CLK);
    start = 1'b1;
    abort = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle got busy=%b wen=%b expected 0/0", busy, ram_wen);
    end
  endtask

  task automatic test_reset_mid;
    logic [PW-1:0] g;
    g = rand_pins(7);
    issue(8'd4, 8'd1, 8'hFF, g, g);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    checks++;
    if (ram_wen !== 1'b1 || busy !== 1'b1 || green !== 8'd3) begin
      errors++;
      $display("FAIL reset_mid_pre got wen=%b busy=%b green=%0d expected 1/1/3", ram_wen, busy, green);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({busy, done, win, err, ram_wen, green, yellow, ram_waddr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b wen=%b green=%0d addr=%0h expected all zero",
               busy, ram_wen, green, ram_waddr);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_range_check;
    logic exp_err;
    logic [7:0] exp_y, exp_g;
`ifdef SCORER_RANGE_CHECK_EN
    exp_err = 1'b1; exp_y = 8'hFF; exp_g = 8'hFF;
`else
    exp_err = 1'b0; exp_y = 8'd2;  exp_g = 8'd1;
`endif
    issue(8'd4, 8'd5, 8'd6, pack5(0, 7, 1, 2, 0), pack5(0, 1, 2, 3, 0));
    collect(40);
    checks++;
    if (got_err !== exp_err || got_win !== 1'b0 || done_cyc != 11) begin
      errors++;
      $display("FAIL range_flags got err=%b win=%b done_cyc=%0d expected %b/0/11",
               got_err, got_win, done_cyc, exp_err);
    end
    checks++;
    if (wd_q.size() != 6 || wd_q[4] !== exp_y || wd_q[5] !== exp_g) begin
      errors++;
      $display("FAIL range_hints got %0d writes, hints %0h/%0h expected 6, %0h/%0h",
               wd_q.size(), (wd_q.size() > 4) ? wd_q[4] : 8'h0, (wd_q.size() > 5) ? wd_q[5] : 8'h0,
               exp_y, exp_g);
    end
    issue(8'd4, 8'd6, 8'd6, pack5(1, 2, 3, 4, 0), pack5(1, 2, 3, 4, 0));
    collect(40);
    checks++;
    if (got_err !== 1'b0 || got_win !== 1'b1 || got_green !== 8'd4) begin
      errors++;
      $display("FAIL range_clear got err=%b win=%b green=%0d expected 0/1/4", got_err, got_win, got_green);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    pins_count = '0;
    pin_colors = '0;
    row        = '0;
    guess      = '0;
    secret     = '0;
    repeat (3) @(posedge CLK);
    #1;
    test_reset;
    @(negedge CLK);
    RST_N = 1'b1;
    test_scoring;
    test_busy_start;
    test_abort;
    test_reset_mid;
    test_range_check;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
